// File: rtl/sdram_stream_writer.sv
// sdram_stream_writer
//   Feeds the sdram_ctrl write port from a valid/ready word stream. Words are
//   buffered in a show-ahead FIFO and issued as wreq/waddr/wdata. Each start
//   writes one frame of FRAME_WORDS words at consecutive addresses, beginning
//   at base_addr. The FIFO lets a bursty source ride through controller stalls.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, base_addr      begin a frame when idle; base sampled on acceptance
//   in_valid/in_ready     source handshake, in_data is the source word
//   wreq/wgnt             write request; a word is consumed on wreq && wgnt
//   waddr, wdata          address and data of the current FIFO head
//   busy, done            frame in progress; done pulses after the last grant
//   level                 FIFO occupancy
module sdram_stream_writer #(
    parameter int DEPTH       = 16,
    parameter int FRAME_WORDS = 1024,
    parameter int AW          = 24,
    parameter int DW          = 16,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          wreq,
    input  logic          wgnt,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] level
);
    localparam int CW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [LW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] rptr_q, rptr_d;
    logic [DW-1:0] last_q, last_d;
    logic [DW-1:0] mem [DEPTH];

    logic full, empty, push, pop;
    logic [DW-1:0] head;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign level = wptr_q - rptr_q;
    assign full  = (level == LW'(DEPTH));
    assign empty = (wptr_q == rptr_q);
    assign head  = mem[rptr_q[LW-2:0]];
    assign push  = in_valid && in_ready;
    assign pop   = wreq && wgnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pop && wr_cnt_q == CW'(FRAME_WORDS - 1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registers, never on wgnt or in_valid.
    always_comb begin
        in_ready = (state_q == RUN) && !full && (in_cnt_q < CW'(FRAME_WORDS));
        wreq     = (state_q == RUN) && !empty;
        busy     = (state_q != IDLE);
        done     = (state_q == FIN);
        waddr    = addr_q;
        // When empty, keep showing the most recently consumed word.
        wdata    = empty ? last_q : head;
    end

    // Datapath next-state
    always_comb begin
        addr_d   = addr_q;
        in_cnt_d = in_cnt_q;
        wr_cnt_d = wr_cnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        last_d   = last_q;
        if (state_q == IDLE) begin
            if (start) begin
                addr_d   = base_addr;
                in_cnt_d = '0;
                wr_cnt_d = '0;
                wptr_d   = '0;
                rptr_d   = '0;
            end
        end else if (state_q == RUN) begin
            if (push) begin
                wptr_d   = wptr_q + LW'(1);
                in_cnt_d = in_cnt_q + CW'(1);
            end
            if (pop) begin
                rptr_d   = rptr_q + LW'(1);
                addr_d   = addr_q + AW'(1);  // wraps modulo 2^AW
                wr_cnt_d = wr_cnt_q + CW'(1);
                last_d   = head;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            in_cnt_q <= '0;
            wr_cnt_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            last_q   <= '0;
        end else begin
            addr_q   <= addr_d;
            in_cnt_q <= in_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[LW-2:0]] <= in_data;
    end
endmodule

// File: tb/tb_sdram_stream_writer.sv
module tb_sdram_stream_writer;
    localparam int DEPTH = 16;
    localparam int FW    = 40;
    localparam int AW    = 24;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 0;
    logic          rst = 1;
    logic          start = 0;
    logic [AW-1:0] base_addr = '0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          wreq;
    logic          wgnt = 0;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy, done;
    logic [LW-1:0] level;

    sdram_stream_writer #(.DEPTH(DEPTH), .FRAME_WORDS(FW), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wreq(wreq), .wgnt(wgnt), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .level(level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of accepted words; address of the
    // k-th granted word is base + k modulo 2^AW.
    bit            m_run, m_done;
    logic [AW-1:0] m_base;
    int            m_acc, m_gr;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_last;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_base = '0; m_acc = 0; m_gr = 0;
        m_q.delete(); m_last = '0;
    endtask

    initial model_reset();

    // Check at the falling edge, then advance the model for the coming rising edge.
    always @(negedge clk) begin
        bit            e_rdy, e_wreq;
        logic [AW-1:0] e_addr;
        if (rst) model_reset();
        e_rdy  = m_run && (m_q.size() < DEPTH) && (m_acc < FW);
        e_wreq = m_run && (m_q.size() > 0);
        e_addr = m_base + AW'(m_gr);
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("wreq",     32'(wreq),     32'(e_wreq));
        chk("busy",     32'(busy),     32'(m_run || m_done));
        chk("done",     32'(done),     32'(m_done));
        chk("level",    32'(level),    32'(m_q.size()));
        chk("waddr",    32'(waddr),    32'(e_addr));
        chk("wdata",    32'(wdata),    32'(m_q.size() > 0 ? m_q[0] : m_last));
        if (!rst) begin
            if (m_done) m_done = 0;
            else if (!m_run) begin
                if (start) begin
                    m_run = 1; m_base = base_addr; m_acc = 0; m_gr = 0; m_q.delete();
                end
            end else begin
                if (e_wreq && wgnt) begin
                    m_last = m_q.pop_front();
                    m_gr++;
                    if (m_gr == FW) begin m_run = 0; m_done = 1; end
                end
                if (in_valid && e_rdy) begin
                    m_q.push_back(in_data);
                    m_acc++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 0; wgnt = 0;
        repeat (n) step();
    endtask

    task automatic pulse_start(input logic [AW-1:0] base);
        start = 1; base_addr = base;
        step();
        start = 0; base_addr = AW'($urandom);
    endtask

    // Random valid/grant until the frame completes or the budget runs out.
    task automatic finish_frame(input int pv, input int pg);
        for (int i = 0; i < 4000; i++) begin
            if (!m_run && !m_done) break;
            in_valid = ($urandom_range(99) < pv);
            in_data  = DW'($urandom);
            wgnt     = ($urandom_range(99) < pg);
            step();
        end
        chk("frame_end_busy", 32'(busy), 32'(0));
        idle(2);
    endtask

    initial begin
        // Reset, idle, then a second 3-cycle reset while idle
        idle(3);
        rst = 0;
        idle(3);
        rst = 1;
        idle(3);
        rst = 0;
        idle(2);
        chk("idle_in_ready", 32'(in_ready), 32'(0));

        // Basic full-rate frame
        pulse_start(24'h000100);
        finish_frame(100, 100);

        // Stall grants: FIFO fills, head stays put, then back-to-back drain
        pulse_start(24'h002000);
        in_valid = 1; wgnt = 0;
        for (int i = 0; i < 30; i++) begin
            in_data = DW'($urandom);
            step();
        end
        chk("stall_level", 32'(level), 32'(DEPTH));
        finish_frame(100, 100);

        // Address wrap at the top of the address space
        pulse_start(24'hFFFFFE);
        finish_frame(70, 70);

        // Ignored restart mid-frame, then reset while words are pending
        pulse_start(24'h000200);
        for (int i = 0; i < 200 && m_gr < 2; i++) begin
            start = (i == 1); base_addr = 24'h000999;
            in_valid = 1; in_data = DW'($urandom); wgnt = (i > 2);
            step();
        end
        start = 0; wgnt = 0;
        rst = 1; #1;
        chk("rst_wreq", 32'(wreq), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        idle(2);
        rst = 0;
        idle(1);
        pulse_start(24'h000300);
        finish_frame(80, 80);

        // Simultaneous push and pop at DEPTH-1
        pulse_start(24'h004000);
        wgnt = 0; in_valid = 1;
        for (int i = 0; i < 100 && m_q.size() < DEPTH - 1; i++) begin
            in_data = DW'($urandom);
            step();
        end
        wgnt = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = DW'($urandom);
            step();
            chk("lvl_dm1", 32'(level), 32'(DEPTH - 1));
        end
        finish_frame(60, 60);

        // Random stall frames
        for (int f = 0; f < 6; f++) begin
            pulse_start(AW'($urandom));
            finish_frame($urandom_range(20, 100), $urandom_range(20, 100));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
